// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment glyph table, dp index and scan FSM state codes
package seg_pkg;

    localparam int SEG_DP  = 7;
    localparam int GLYPH_W = 7;

    // Entry v occupies bits [7v+6:7v]; the encoder side indexes the same constant.
    localparam logic [16*GLYPH_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SETTLE  = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_HOLD    = 2'd3;

    function automatic logic [GLYPH_W-1:0] glyph_of(input logic [3:0] v);
        return GLYPH_TABLE[v*GLYPH_W +: GLYPH_W];
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational 7-segment pattern to hex nibble with error flag
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [GLYPH_W-1:0] pattern_i,
    output logic [3:0]         nibble_o,
    output logic               err_o
);

    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == glyph_of(i[3:0])) begin
                nibble_o = i[3:0];
                err_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples a multiplexed 7-segment bus and emits decoded N-digit frames
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = $clog2(STABLE_CYC + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_code,
    input  logic [N_DIGITS-1:0]   digit_sel,
    output logic [4*N_DIGITS-1:0] out_value,
    output logic [N_DIGITS-1:0]   out_dp,
    output logic [N_DIGITS-1:0]   out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC);

    state_t                  state_q, state_d;
    logic [N_DIGITS-1:0]     sel_q, sel_d;
    logic [7:0]              code_q, code_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   sh_val_q, sh_val_d;
    logic [N_DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [N_DIGITS-1:0]     sh_err_q, sh_err_d;
    logic [N_DIGITS-1:0]     mask_q, mask_d;
    logic [4*N_DIGITS-1:0]   out_value_q, out_value_d;
    logic [N_DIGITS-1:0]     out_dp_q, out_dp_d;
    logic [N_DIGITS-1:0]     out_err_q, out_err_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic                    sel_onehot;
    logic                    sel_changed;
    logic                    code_changed;
    logic                    frame_done;
    logic                    accept;
    logic [3:0]              dec_nibble;
    logic                    dec_err;

    seg_glyph_decode u_decode (
        .pattern_i (code_q[GLYPH_W-1:0]),
        .nibble_o  (dec_nibble),
        .err_o     (dec_err)
    );

    assign sel_onehot   = (digit_sel != '0) && ((digit_sel & (digit_sel - 1'b1)) == '0);
    assign sel_changed  = (digit_sel != sel_q);
    assign code_changed = (seg_code != code_q);
    assign accept       = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        sh_val_d    = sh_val_q;
        sh_dp_d     = sh_dp_q;
        sh_err_d    = sh_err_q;
        mask_d      = mask_q;
        out_value_d = out_value_q;
        out_dp_d    = out_dp_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        frame_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_onehot) begin
                    state_d = ST_SETTLE;
                    sel_d   = digit_sel;
                    code_d  = seg_code;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (sel_changed || code_changed) begin
                    if (sel_onehot) begin
                        sel_d  = digit_sel;
                        code_d = seg_code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q >= STABLE_MAX) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        sh_val_d[4*i +: 4] = dec_nibble;
                        sh_dp_d[i]         = code_q[SEG_DP];
                        sh_err_d[i]        = dec_err;
                    end
                end
                mask_d  = mask_q | sel_q;
                state_d = ST_HOLD;
                if (&mask_d) begin
                    frame_done = 1'b1;
                    mask_d     = '0;
                end
            end
            ST_HOLD: begin
                // Code changes under an unchanged select are ignored until the scan moves on.
                if (sel_changed) begin
                    if (sel_onehot) begin
                        state_d = ST_SETTLE;
                        sel_d   = digit_sel;
                        code_d  = seg_code;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end

        // A frame only lands if the output slot is empty or being drained this cycle.
        if (frame_done) begin
            if (!out_valid_q || accept) begin
                out_value_d = sh_val_d;
                out_dp_d    = sh_dp_d;
                out_err_d   = sh_err_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            code_q      <= '0;
            cnt_q       <= '0;
            sh_val_q    <= '0;
            sh_dp_q     <= '0;
            sh_err_q    <= '0;
            mask_q      <= '0;
            out_value_q <= '0;
            out_dp_q    <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            sh_val_q    <= sh_val_d;
            sh_dp_q     <= sh_dp_d;
            sh_err_q    <= sh_err_d;
            mask_q      <= mask_d;
            out_value_q <= out_value_d;
            out_dp_q    <= out_dp_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_value = out_value_q;
    assign out_dp    = out_dp_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed and randomized self-check of seg_scan_decoder against a run-length model
module tb_seg_scan_decoder;

    localparam int N  = 8;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    seg_code;
    logic [N-1:0]  digit_sel;
    logic [4*N-1:0] out_value;
    logic [N-1:0]  out_dp;
    logic [N-1:0]  out_err;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;

    always #5 clk = ~clk;

    seg_scan_decoder #(.N_DIGITS(N), .STABLE_CYC(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_code  (seg_code),
        .digit_sel (digit_sel),
        .out_value (out_value),
        .out_dp    (out_dp),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          total = 0;
    int          bad   = 0;
    int          accepts = 0;
    int          skip = 0;
    logic [47:0] expq[$];
    logic [31:0] m_val;
    logic [7:0]  m_dp, m_err, m_mask;
    logic [31:0] last_val;
    logic [7:0]  last_dp, last_err;
    logic [7:0]  prev_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    // Samples with the ready value that the coming rising edge will also see.
    task automatic cycle();
        logic [47:0] e;
        if (out_valid && out_ready) begin
            accepts++;
            if (expq.size() == 0) begin
                check("unexpected_frame", 64'(out_valid), 64'd0);
            end else begin
                e = expq.pop_front();
                check("frame_value", 64'(out_value), 64'(e[31:0]));
                check("frame_dp", 64'(out_dp), 64'(e[39:32]));
                check("frame_err", 64'(out_err), 64'(e[47:40]));
            end
            last_val = out_value;
            last_dp  = out_dp;
            last_err = out_err;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        expq.delete();
        m_val = '0; m_dp = '0; m_err = '0; m_mask = '0;
        skip = 0;
    endtask

    // A run of n samples is captured when its select is one-hot and it survives STABLE_CYC+1
    // samples; the capture cycle itself eats the first sample of the following run.
    task automatic run(input logic [7:0] sel, input logic [7:0] code, input int n);
        int eff;
        int d;
        logic [4:0] dec;
        eff  = n - skip;
        skip = 0;
        if ($countones(sel) == 1 && eff >= SC + 1) begin
            d = 0;
            for (int i = 0; i < N; i++) if (sel[i]) d = i;
            dec = model_decode(code[6:0]);
            m_val[4*d +: 4] = dec[3:0];
            m_err[d]        = dec[4];
            m_dp[d]         = code[7];
            m_mask[d]       = 1'b1;
            if (eff == SC + 1) skip = 1;
            if (&m_mask) begin
                if (!(expq.size() != 0 && !out_ready)) expq.push_back({m_err, m_dp, m_val});
                m_mask = '0;
            end
        end
        prev_sel  = sel;
        digit_sel = sel;
        seg_code  = code;
        repeat (n) cycle();
    endtask

    task automatic scan_frame(input logic [31:0] v, input int n);
        for (int d = 0; d < N; d++) run(8'(1 << d), {1'b0, glyph[v[4*d +: 4]]}, n);
    endtask

    initial begin
        int a0;
        logic [7:0] s, c;
        int n;
        rst = 1'b1; digit_sel = '0; seg_code = '0; out_ready = 1'b1;
        prev_sel = '0; last_val = '0; last_dp = '0; last_err = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_value", 64'(out_value), 64'd0);
        check("rst_dp", 64'(out_dp), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;

        a0 = accepts;
        scan_frame(32'h76543210, 10);
        run(8'h00, 8'h00, 10);
        check("basic_count", 64'(accepts - a0), 64'd1);
        check("basic_value", 64'(last_val), 64'h76543210);
        check("basic_err", 64'(last_err), 64'd0);
        check("basic_dp", 64'(last_dp), 64'd0);

        for (int d = 0; d < 3; d++) run(8'(1 << d), {1'b0, glyph[d]}, 10);
        for (int k = 0; k < 6; k++) run(8'h08, k[0] ? 8'h4F : 8'h5B, 2);
        run(8'h08, 8'h77, 10);
        for (int d = 4; d < 8; d++) run(8'(1 << d), {1'b0, glyph[d]}, 10);
        run(8'h00, 8'h00, 10);
        check("toggle_nib3", 64'(last_val[15:12]), 64'hA);

        for (int d = 0; d < 8; d++)
            run(8'(1 << d), (d == 5) ? 8'h00 : (d == 2) ? 8'hFF : {1'b0, glyph[d]}, 10);
        run(8'h00, 8'h00, 10);
        check("blank_err5", 64'(last_err[5]), 64'd1);
        check("ff_err2", 64'(last_err[2]), 64'd0);
        check("ff_nib2", 64'(last_val[11:8]), 64'h8);
        check("ff_dp2", 64'(last_dp[2]), 64'd1);

        out_ready = 1'b0;
        scan_frame(32'h89ABCDEF, 10);
        scan_frame(32'h11111111, 10);
        run(8'h00, 8'h00, 10);
        check("ovr_valid", 64'(out_valid), 64'd1);
        check("ovr_hold", 64'(out_value), 64'h89ABCDEF);
        check("ovr_flag", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();
        check("ovr_clear", 64'(overrun), 64'd0);
        check("ovr_drained", 64'(out_valid), 64'd0);
        check("ovr_value", 64'(last_val), 64'h89ABCDEF);

        for (int d = 0; d < 8; d++) begin
            run(8'(1 << d), {1'b0, glyph[8 + d]}, 8);
            run((d % 2) ? 8'h18 : 8'h00, 8'h7F, 7);
        end
        run(8'h00, 8'h00, 10);
        check("invsel_value", 64'(last_val), 64'hFEDCBA98);

        out_ready = 1'b0;
        scan_frame(32'h13579BDF, 10);
        for (int d = 0; d < 4; d++) run(8'(1 << d), {1'b0, glyph[d]}, 10);
        #2 rst = 1'b1;
        #1;
        check("amid_valid", 64'(out_valid), 64'd0);
        check("amid_value", 64'(out_value), 64'd0);
        check("amid_err", 64'(out_err), 64'd0);
        model_reset();
        digit_sel = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        a0 = accepts;
        scan_frame(32'h02468ACE, 10);
        run(8'h00, 8'h00, 20);
        check("rescan_count", 64'(accepts - a0), 64'd1);
        check("rescan_value", 64'(last_val), 64'h02468ACE);

        for (int k = 0; k < 150; k++) begin
            do begin
                if ($urandom_range(0, 5) == 0) begin
                    s = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7)));
                end else begin
                    s = 8'(1 << $urandom_range(0, 7));
                end
            end while (s == prev_sel);
            c = ($urandom_range(0, 9) < 7) ? {1'($urandom), glyph[$urandom_range(0, 15)]} : 8'($urandom);
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 4) : $urandom_range(5, 12);
            run(s, c, n);
        end
        run(8'h00, 8'h00, 20);
        check("all_frames_seen", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
